// File: rtl/lmc_control_unit.sv
// Little Man Computer fetch/execute sequencer: 2 cycles per instruction, plus the wait for I/O.
// INP stalls until in_valid is high, OUT stalls until out_ready is high, and HLT or an illegal word stops execution until reset.
module lmc_control_unit #(
  parameter int WORD_W = 11,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALT
  } state_t;

  localparam logic [WORD_W-1:0] K99   = WORD_W'(99);
  localparam logic [WORD_W-1:0] K100  = WORD_W'(100);
  localparam logic [WORD_W-1:0] K200  = WORD_W'(200);
  localparam logic [WORD_W-1:0] K300  = WORD_W'(300);
  localparam logic [WORD_W-1:0] K400  = WORD_W'(400);
  localparam logic [WORD_W-1:0] K500  = WORD_W'(500);
  localparam logic [WORD_W-1:0] K600  = WORD_W'(600);
  localparam logic [WORD_W-1:0] K700  = WORD_W'(700);
  localparam logic [WORD_W-1:0] K800  = WORD_W'(800);
  localparam logic [WORD_W-1:0] K900  = WORD_W'(900);
  localparam logic [WORD_W-1:0] K999  = WORD_W'(999);
  localparam logic [WORD_W-1:0] K1000 = WORD_W'(1000);
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(99);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [WORD_W-1:0] acc;
  logic              neg;
  logic [WORD_W-1:0] ir;

  logic [3:0]        opcode;
  logic [WORD_W-1:0] op_rem;
  logic [ADDR_W-1:0] operand;
  logic              ir_bad;
  logic              is_ill;
  logic [WORD_W-1:0] m_val;
  logic [WORD_W-1:0] add_sum;
  logic [WORD_W-1:0] add_res;
  logic [WORD_W-1:0] sub_res;
  logic [WORD_W-1:0] in_clamp;

  // Decimal decode by descending compare-and-subtract.
  always_comb begin
    opcode = 4'd0;
    op_rem = ir;
    if (ir >= K900) begin
      opcode = 4'd9; op_rem = ir - K900;
    end else if (ir >= K800) begin
      opcode = 4'd8; op_rem = ir - K800;
    end else if (ir >= K700) begin
      opcode = 4'd7; op_rem = ir - K700;
    end else if (ir >= K600) begin
      opcode = 4'd6; op_rem = ir - K600;
    end else if (ir >= K500) begin
      opcode = 4'd5; op_rem = ir - K500;
    end else if (ir >= K400) begin
      opcode = 4'd4; op_rem = ir - K400;
    end else if (ir >= K300) begin
      opcode = 4'd3; op_rem = ir - K300;
    end else if (ir >= K200) begin
      opcode = 4'd2; op_rem = ir - K200;
    end else if (ir >= K100) begin
      opcode = 4'd1; op_rem = ir - K100;
    end
  end

  assign ir_bad  = (ir > K999) || (op_rem > K99);
  assign operand = ir_bad ? '0 : op_rem[ADDR_W-1:0];
  assign is_ill  = ir_bad || (opcode == 4'd4) ||
                   ((opcode == 4'd9) && (operand != ADDR_W'(1)) && (operand != ADDR_W'(2))) ||
                   ((opcode == 4'd0) && (operand != '0));

  // Both acc and the clamped operand are at most 999, so every result stays below 2000.
  assign m_val    = (mem_rdata > K999) ? K999 : mem_rdata;
  assign add_sum  = acc + m_val;
  assign add_res  = (add_sum >= K1000) ? (add_sum - K1000) : add_sum;
  assign sub_res  = (acc >= m_val) ? (acc - m_val) : (acc + K1000 - m_val);
  assign in_clamp = (in_data > K999) ? K999 : in_data;

  assign mem_wdata = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_addr  = pc;
    mem_we    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: state_nx = S_EXEC;
      S_EXEC: begin
        mem_addr = operand;
        mem_we   = !is_ill && (opcode == 4'd3);
        if (is_ill || (opcode == 4'd0)) begin
          state_nx = S_HALT;
        end else if ((opcode == 4'd9) && (operand == ADDR_W'(1))) begin
          state_nx = S_WAIT_IN;
        end else if (opcode == 4'd9) begin
          state_nx = S_WAIT_OUT;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_FETCH;
      end
      S_WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      ir       <= '0;
      out_data <= '0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir <= mem_rdata;
          pc <= (pc == PC_LAST) ? '0 : pc + 1'b1;
        end
        S_EXEC: begin
          if (is_ill) begin
            illegal <= 1'b1;
          end else begin
            case (opcode)
              4'd1: begin acc <= add_res; neg <= 1'b0; end
              4'd2: begin acc <= sub_res; neg <= (acc < m_val); end
              4'd5: begin acc <= m_val;   neg <= 1'b0; end
              4'd6: pc <= operand;
              4'd7: if ((acc == '0) && !neg) pc <= operand;
              4'd8: if (!neg) pc <= operand;
              4'd9: if (operand == ADDR_W'(2)) out_data <= acc;
              default: ;
            endcase
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            acc <= in_clamp;
            neg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lmc_control_unit.md
# lmc_control_unit

Fetch/execute sequencer for the Little Man Computer core. Drives the 100-word unified memory's address, write data and write enable, consumes its combinational read data, and executes the decimal LMC instruction set on an internal accumulator. Sits directly upstream of the memory. Owns the program counter, the accumulator, the negative flag and the INP/OUT handshakes to the outside world.

## Interface
Parameters:
- `WORD_W`, default 11: memory and I/O word width. Values are 0..999.
- `ADDR_W`, default 7: memory address width. Addresses are 0..99.

Ports:
- `clk`  in  1  single clock. Memory writes happen on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  ADDR_W  memory address (combinational from state).
- `mem_wdata`  out  WORD_W  memory write data (always equals the accumulator).
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  WORD_W  memory read data, valid in the same cycle as `mem_addr`.
- `in_data`  in  WORD_W  INP value.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  waiting for INP.
- `out_data`  out  WORD_W  OUT value, registered.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `halted`  out  1  execution has stopped (HLT or illegal instruction).
- `illegal`  out  1  the stop was caused by an illegal instruction.

## Operation
- Decode of `ir`:
  - opcode = `ir`/100.
  - operand = `ir`%100, always 0..99.
  - Implement the decode with compares/subtracts. No generic divider.
- Instruction set:
  - 1xx ADD: acc = (acc+M[xx]) mod 1000; neg cleared.
  - 2xx SUB: if acc ≥ M[xx], acc = acc−M[xx] and neg is cleared. Otherwise acc = acc−M[xx]+1000 and neg is set.
  - 3xx STA: M[xx] = acc.
  - 5xx LDA: acc = M[xx]; neg cleared.
  - 6xx BRA: pc = xx.
  - 7xx BRZ: pc = xx if acc==0 and neg==0.
  - 8xx BRP: pc = xx if neg==0.
  - 901 INP: acc = min(`in_data`, 999); neg cleared.
  - 902 OUT: `out_data` = acc.
  - 000 HLT.
- Illegal instructions: 4xx, 9xx other than 901/902, 001–099, and any `mem_rdata` > 999. They halt with `illegal`=1.
- Memory operands and M[xx] values above 999 are treated as 999.
- States:
  - FETCH
    - `mem_addr`=pc.
    - Latch `ir` = `mem_rdata`.
    - pc = (pc==99) ? 0 : pc+1.
    - Next state is EXEC.
  - EXEC
    - `mem_addr`=operand.
    - `mem_we`=1 only for STA.
    - ADD/SUB/LDA use `mem_rdata`.
    - Next state: FETCH. Exceptions: INP goes to WAIT_IN, OUT loads `out_data` and goes to WAIT_OUT, HLT/illegal go to HALT.
  - WAIT_IN
    - `in_ready`=1.
    - On `in_valid`, load acc and go to FETCH.
  - WAIT_OUT
    - `out_valid`=1.
    - On `out_ready`, go to FETCH.
  - HALT
    - `halted`=1.
    - `mem_we`=0.
    - Terminal until reset.
- A branch target ≥ 100 cannot occur, because the operand is at most 99.

## Timing
- Reset values, asserted immediately and asynchronously:
  - pc=0, acc=0, neg=0, `ir`=0, state=FETCH.
  - `mem_we`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `halted`=0, `illegal`=0.
  - `mem_addr`=0.
- Latency:
  - Non-I/O instructions take exactly 2 cycles (FETCH, EXEC).
  - INP takes 2 cycles + the `in_valid` wait, minimum 3.
  - OUT takes 2 cycles + the `out_ready` wait, minimum 3.
- STA: `mem_we` is high for the single EXEC cycle. The memory captures `mem_wdata` on the closing edge. The next FETCH sees the written value.
- Handshakes:
  - Transfer happens on a rising edge with valid&ready both high.
  - `in_ready` is high throughout WAIT_IN. `in_valid` already high on entry completes the transfer in 1 cycle.
  - `out_data` is stable while `out_valid`=1.
  - `in_valid` outside WAIT_IN is ignored.
- `halted` and `illegal` rise on the edge that ends EXEC of the stopping instruction.
- A self-modifying STA to pc's own next address takes effect on the next fetch.

## Test plan
- Add with wrap and store:
  - Stimulus: M = {0:510, 1:111, 2:312, 3:000, 10:400, 11:700}.
  - Required: M[12]=100, neg=0, `halted`=1 at cycle 8, `illegal`=0.
- SUB negative, then branches:
  - Stimulus: M = {0:510, 1:211, 2:806, 3:705, 4:000, 5:000, 6:000, 10:5, 11:7}.
  - Required: acc=998, neg=1, BRP not taken, BRZ not taken, halt with pc=5.
- Handshakes:
  - Stimulus: program 901, 902, 000. Hold `in_valid` low for 5 cycles, then present 42. Hold `out_ready` low for 3 cycles.
  - Required: `in_ready` high for 6 cycles. `out_data`=42 held stable with `out_valid`=1 for 4 cycles. INP of 1500 loads 999.
- PC wrap:
  - Stimulus: M = {0:699, 99:510, 10:3}.
  - Required: after the instruction at 99 executes, fetch address returns to 0, then the BRA loops back to 99.
- Illegal opcode:
  - Stimulus: M[0]=400. A separate run uses M[0]=1200.
  - Required: `halted`=1 and `illegal`=1 after 2 cycles, `mem_we` never asserted, state frozen for 20 further cycles.
- Reset mid-operation:
  - Stimulus: assert `reset` between edges during WAIT_OUT and during an STA EXEC.
  - Required: `out_valid`, `mem_we` and `halted` fall immediately. After release, fetch restarts at address 0 with acc=0.
